text_scan_scheduler: RTL and testbench

- Sequencing controller for the 8-digit, 18-bit-code text display.
- Selects which message the text decode block presents: EC311, FPGA, bUrGEr or VErILOG. Selection comes from debounced switches or from automatic rotation.
- Time-multiplexes the eight digit anodes, with a blanking slot per digit to suppress ghosting.
- Message changes commit only at frame boundaries, so a frame never shows a mix of two messages.

---
 rtl/text_scan_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_text_scan_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/text_scan_scheduler.sv
// Digit scan, switch debounce and message sequencing for the 8-digit text display.
// Message changes are committed only on the digit 7->0 wrap, so every frame shows a single message.
module text_scan_scheduler #(
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 256,
  parameter int DEBOUNCE     = 16
) (
  input  logic       divided_clk,
  input  logic       reset_n,
  input  logic       auto_en,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  output logic [2:0] msg_sel,
  output logic [2:0] digit_idx,
  output logic [7:0] anode_n,
  output logic       blank,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DWELL_FRAMES) + 1;
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [BW-1:0] DB_LEN     = BW'(DEBOUNCE);

  typedef enum logic [0:0] {AUTO = 1'b0, MANUAL = 1'b1} state_t;

  function automatic logic [2:0] map_request(input logic [2:0] d);
    case (d)
      3'b100, 3'b010, 3'b001: map_request = d;
      default:                map_request = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] next_auto(input logic [2:0] m);
    case (m)
      3'b000:  next_auto = 3'b100;
      3'b100:  next_auto = 3'b010;
      3'b010:  next_auto = 3'b001;
      default: next_auto = 3'b000;
    endcase
  endfunction

  logic          running;
  logic [CW-1:0] scan_cnt, scan_nxt;
  logic [2:0]    digit_nxt;
  logic          frame_edge;
  logic [2:0]    sync1, sync2, samp, deb;
  logic [BW-1:0] run_cnt, run_len;
  state_t        state, state_nxt;
  logic [2:0]    pending, pending_nxt;
  logic [DW-1:0] dwell, dwell_nxt;

  // Next scan position; the first edge after reset only arms the counter at digit 0, cycle 0
  always_comb begin
    scan_nxt   = {CW{1'b0}};
    digit_nxt  = 3'd0;
    frame_edge = 1'b0;
    if (!running) begin
      scan_nxt  = {CW{1'b0}};
      digit_nxt = 3'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_nxt   = {CW{1'b0}};
      digit_nxt  = digit_idx + 3'd1;
      frame_edge = (digit_idx == 3'd7);
    end else begin
      scan_nxt  = scan_cnt + CW'(1);
      digit_nxt = digit_idx;
    end
  end

  // Scan counters and registered scan outputs, decoded from the position being entered
  always_ff @(posedge divided_clk or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      scan_cnt    <= {CW{1'b0}};
      digit_idx   <= 3'd0;
      anode_n     <= 8'hFF;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      scan_cnt    <= scan_nxt;
      digit_idx   <= digit_nxt;
      blank       <= (scan_nxt == {CW{1'b0}});
      anode_n     <= (scan_nxt == {CW{1'b0}}) ? 8'hFF : ~(8'h01 << digit_nxt);
      frame_start <= (scan_nxt == {CW{1'b0}}) && (digit_nxt == 3'd0);
    end
  end

  // Length of the current run of identical synchronized samples, saturating at DEBOUNCE
  always_comb begin
    run_len = BW'(1);
    if (sync2 == samp) begin
      run_len = (run_cnt == DB_LEN) ? run_cnt : run_cnt + BW'(1);
    end else begin
      run_len = BW'(1);
    end
  end

  // Two-flop synchronizer followed by the run-length debouncer
  always_ff @(posedge divided_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 3'b000;
      sync2   <= 3'b000;
      samp    <= 3'b000;
      deb     <= 3'b000;
      run_cnt <= {BW{1'b0}};
    end else begin
      sync1   <= {switch1, switch2, switch3};
      sync2   <= sync1;
      samp    <= sync2;
      run_cnt <= run_len;
      if (run_len == DB_LEN) begin
        deb <= sync2;
      end else begin
        deb <= deb;
      end
    end
  end

  // Message FSM; a manual request takes priority over an auto advance due on the same edge
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    dwell_nxt   = dwell;
    case (state)
      AUTO: begin
        if (deb != 3'b000) begin
          state_nxt   = MANUAL;
          pending_nxt = map_request(deb);
        end else if (auto_en && frame_edge) begin
          if (dwell == DWELL_LAST) begin
            dwell_nxt   = {DW{1'b0}};
            pending_nxt = next_auto(pending);
          end else begin
            dwell_nxt = dwell + DW'(1);
          end
        end else begin
          dwell_nxt = dwell;
        end
      end
      MANUAL: begin
        if (deb == 3'b000) begin
          state_nxt   = AUTO;
          pending_nxt = 3'b000;
          dwell_nxt   = {DW{1'b0}};
        end else begin
          pending_nxt = map_request(deb);
        end
      end
      default: begin
        state_nxt   = AUTO;
        pending_nxt = 3'b000;
        dwell_nxt   = {DW{1'b0}};
      end
    endcase
  end

  // FSM state plus frame-boundary commit of the pending message
  always_ff @(posedge divided_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= AUTO;
      pending <= 3'b000;
      dwell   <= {DW{1'b0}};
      msg_sel <= 3'b000;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      dwell   <= dwell_nxt;
      if (frame_edge) begin
        msg_sel <= pending;
      end else begin
        msg_sel <= msg_sel;
      end
    end
  end

endmodule

// File: tb/tb_text_scan_scheduler.sv
// Self-checking bench for text_scan_scheduler: scan pattern checked every cycle,
// per-frame msg_sel expectations held in a scoreboard queue and popped on each frame start.
module tb_text_scan_scheduler;

  localparam int SCAN_DIV     = 4;
  localparam int DWELL_FRAMES = 2;
  localparam int DEBOUNCE     = 3;
  localparam int FRAME        = 8 * SCAN_DIV;
  localparam logic [2:0] PLAN [23] = '{
    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100,
    3'b010, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b010,
    3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b010
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       auto_en = 1'b0;
  logic       switch1 = 1'b0;
  logic       switch2 = 1'b0;
  logic       switch3 = 1'b0;
  logic [2:0] msg_sel;
  logic [2:0] digit_idx;
  logic [7:0] anode_n;
  logic       blank;
  logic       frame_start;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_pos;
  int         m_slot;
  bit         mon_en = 1'b0;
  logic [2:0] exp_msg_q [$];
  logic [2:0] cur_msg = 3'b000;

  text_scan_scheduler #(
    .SCAN_DIV(SCAN_DIV),
    .DWELL_FRAMES(DWELL_FRAMES),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .divided_clk(clk),
    .reset_n(reset_n),
    .auto_en(auto_en),
    .switch1(switch1),
    .switch2(switch2),
    .switch3(switch3),
    .msg_sel(msg_sel),
    .digit_idx(digit_idx),
    .anode_n(anode_n),
    .blank(blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic set_sw(input logic [2:0] v);
    {switch1, switch2, switch3} = v;
  endtask

  task automatic at_cycle(input int c);
    int guard;
    guard = 0;
    while (cyc != c + 1) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL at_cycle: cycle %0d never reached, cycle counter %0d", c, cyc);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "cycle bound expired");
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_anode"}, anode_n, 8'hFF);
    check_eq({tag, "_blank"}, {7'b0, blank}, 8'h01);
    check_eq({tag, "_fstart"}, {7'b0, frame_start}, 8'h00);
    check_eq({tag, "_digit"}, {5'b0, digit_idx}, 8'h00);
    check_eq({tag, "_msg"}, {5'b0, msg_sel}, 8'h00);
  endtask

  // Cycle-by-cycle scan pattern and frame-stable msg_sel checks
  always @(negedge clk) begin
    if (mon_en) begin
      m_pos  = cyc % SCAN_DIV;
      m_slot = (cyc % FRAME) / SCAN_DIV;
      check_eq("frame_start", {7'b0, frame_start}, {7'b0, ((cyc % FRAME) == 0)});
      check_eq("blank", {7'b0, blank}, {7'b0, (m_pos == 0)});
      check_eq("digit_idx", {5'b0, digit_idx}, 8'(m_slot));
      check_eq("anode_n", anode_n, (m_pos == 0) ? 8'hFF : ~(8'h01 << m_slot));
      if ((cyc % FRAME) == 0 && exp_msg_q.size() > 0) begin
        cur_msg = exp_msg_q.pop_front();
      end
      check_eq("msg_sel", {5'b0, msg_sel}, {5'b0, cur_msg});
      cyc++;
    end else begin
      cyc = 0;
    end
  end

  initial begin
    for (int i = 0; i < 23; i++) exp_msg_q.push_back(PLAN[i]);

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // short glitch, then a long pulse that reverts inside frame 2
    at_cycle(40);  set_sw(3'b100);
    at_cycle(42);  set_sw(3'b000);
    at_cycle(72);  set_sw(3'b100);
    at_cycle(82);  set_sw(3'b000);

    // auto rotation from frame 3 onward
    at_cycle(104); auto_en = 1'b1;

    // manual override, multi-hot, release back to auto
    at_cycle(456); set_sw(3'b010);
    at_cycle(488); set_sw(3'b110);
    at_cycle(520); set_sw(3'b000);

    // manual request while an auto advance is due at the next boundary
    at_cycle(616); set_sw(3'b001);
    at_cycle(680); set_sw(3'b010);

    // asynchronous reset in digit 5 while 010 is displayed
    at_cycle(726);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check_eq("queue_drained", 8'(exp_msg_q.size()), 8'h00);

    set_sw(3'b000);
    auto_en = 1'b0;
    exp_msg_q.push_back(3'b000);
    exp_msg_q.push_back(3'b000);
    cur_msg = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    at_cycle(70);
    mon_en = 1'b0;
    check_eq("queue_drained_end", 8'(exp_msg_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
